// File: rtl/le18_pkg.sv
// Shared constants and types for the LE18 graphics RAM port-A controller.
package le18_pkg;

  // Z80 I/O port map
  localparam logic [7:0] PORT_FILL = 8'hEB;
  localparam logic [7:0] PORT_DATA = 8'hEC;
  localparam logic [7:0] PORT_X    = 8'hED;
  localparam logic [7:0] PORT_Y    = 8'hEE;
  localparam logic [7:0] PORT_OPT  = 8'hEF;

  // Option register bit positions
  localparam int OPT_EN  = 0;
  localparam int OPT_INC = 1;

  // Fill engine states
  typedef enum logic {IDLE, FILL} fill_state_t;

endpackage

// File: rtl/le18_io_edge_strobe.sv
// Registered-condition rising-edge detector followed by a three-stage pulse
// train. hit marks the detection cycle T; one/two/three follow at T+1..T+3.
module io_edge_strobe (
  input  logic clk,
  input  logic srst,
  input  logic cond,
  output logic hit,
  output logic one,
  output logic two,
  output logic three
);

  logic cond_q;
  logic cond_qq;

  // Register the raw condition, then walk the detected edge down the train
  always_ff @(posedge clk) begin
    if (srst) begin
      cond_q  <= 1'b0;
      cond_qq <= 1'b0;
      one     <= 1'b0;
      two     <= 1'b0;
      three   <= 1'b0;
    end else begin
      cond_q  <= cond;
      cond_qq <= cond_q;
      one     <= hit;
      two     <= one;
      three   <= two;
    end
  end

  assign hit = cond_q & ~cond_qq;

endmodule

// File: rtl/le18_port_ctrl.sv
// LE18 graphics RAM port-A controller: Z80 port decode, X/Y/option
// registers, Z80 read/write sequencing and a whole-bitmap fill engine that
// yields the RAM port to the Z80 whenever the Z80 claims it.
module le18_port_ctrl
  import le18_pkg::*;
#(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 6,
  parameter int FILL_LAST = 16383
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              io_access,
  input  logic [7:0]        trs_a,
  input  logic [7:0]        trs_d,
  input  logic              trs_in_n,
  input  logic              trs_out_n,
  output logic              mem_ce,
  output logic              mem_we,
  output logic              mem_regce,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [7:0]        rd_data,
  output logic              rd_rdy,
  output logic              le18_enable,
  output logic              busy
);

  localparam int R_X    = 0;
  localparam int R_Y    = 1;
  localparam int R_OPT  = 2;
  localparam int R_FILL = 3;

  logic        out_sel;
  logic [3:0]  reg_cond;
  logic [3:0]  reg_q;
  logic [3:0]  reg_qq;
  logic [3:0]  reg_hit;
  logic [7:0]  d_q;
  logic        wr_cond;
  logic        rd_cond;
  logic        wr_hit, wr_one, wr_two, wr_three;
  logic        rd_hit, rd_one, rd_two, rd_three;
  logic        z80_slot;
  logic        step_inc;
  logic [5:0]  x_ptr;
  logic [7:0]  y_ptr;
  logic [1:0]  opt;
  fill_state_t state;
  logic [ADDR_W-1:0] fill_addr;
  logic [DATA_W-1:0] fill_val;
  logic [7:0]  rd_live;
  logic [7:0]  rd_hold;
  logic        unused_strobes;

  // Port decode: each condition is qualifier & address match & strobe
  assign out_sel  = io_access & ~trs_out_n;
  assign reg_cond = {out_sel & (trs_a == PORT_FILL),
                     out_sel & (trs_a == PORT_OPT),
                     out_sel & (trs_a == PORT_Y),
                     out_sel & (trs_a == PORT_X)};
  assign wr_cond  = out_sel & (trs_a == PORT_DATA);
  assign rd_cond  = io_access & ~trs_in_n & (trs_a == PORT_DATA);

  // Register-port conditions and the data bus, registered side by side so
  // the captured byte lines up with the detected edge
  always_ff @(posedge clk) begin
    if (srst) begin
      reg_q  <= '0;
      reg_qq <= '0;
      d_q    <= '0;
    end else begin
      reg_q  <= reg_cond;
      reg_qq <= reg_q;
      d_q    <= trs_d;
    end
  end

  assign reg_hit = reg_q & ~reg_qq;

  io_edge_strobe u_wr_strobe (
    .clk   (clk),
    .srst  (srst),
    .cond  (wr_cond),
    .hit   (wr_hit),
    .one   (wr_one),
    .two   (wr_two),
    .three (wr_three)
  );

  io_edge_strobe u_rd_strobe (
    .clk   (clk),
    .srst  (srst),
    .cond  (rd_cond),
    .hit   (rd_hit),
    .one   (rd_one),
    .two   (rd_two),
    .three (rd_three)
  );

  // The write side needs only the edge and its first follow-up stage
  assign unused_strobes = wr_two ^ wr_three;

  // A Z80 data-port edge owns the RAM port on the following cycle
  assign z80_slot = wr_hit | rd_hit;
  // Increment lands one cycle after the RAM used the address
  assign step_inc = opt[OPT_INC] & (wr_one | rd_one);

  // X/Y/option registers; an explicit register write beats auto-increment
  always_ff @(posedge clk) begin
    if (srst) begin
      x_ptr <= '0;
      y_ptr <= '0;
      opt   <= '0;
    end else begin
      if (reg_hit[R_X]) begin
        x_ptr <= d_q[5:0];
      end else if (step_inc) begin
        x_ptr <= x_ptr + 6'd1;
      end
      if (reg_hit[R_Y]) begin
        y_ptr <= d_q;
      end else if (step_inc && (x_ptr == 6'd63)) begin
        y_ptr <= y_ptr + 8'd1;
      end
      if (reg_hit[R_OPT]) begin
        opt <= d_q[1:0];
      end
    end
  end

  // Fill FSM and RAM port arbitration; Z80 slot first, fill writes otherwise
  always_ff @(posedge clk) begin
    if (srst) begin
      state     <= IDLE;
      fill_addr <= '0;
      fill_val  <= '0;
      busy      <= 1'b0;
      mem_ce    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
    end else begin
      mem_ce <= 1'b0;
      mem_we <= 1'b0;
      // busy trails the FSM by one cycle so it covers the final write
      busy   <= (state == FILL) | reg_hit[R_FILL];

      if (z80_slot) begin
        mem_ce   <= 1'b1;
        mem_we   <= wr_hit;
        mem_addr <= ADDR_W'({y_ptr, x_ptr});
        if (wr_hit) begin
          mem_din <= d_q[DATA_W-1:0];
        end
      end else if ((state == FILL) && !reg_hit[R_FILL]) begin
        mem_ce   <= 1'b1;
        mem_we   <= 1'b1;
        mem_addr <= fill_addr;
        mem_din  <= fill_val;
      end

      if (reg_hit[R_FILL]) begin
        state     <= FILL;
        fill_addr <= '0;
        fill_val  <= d_q[DATA_W-1:0];
      end else if ((state == FILL) && !z80_slot) begin
        fill_addr <= fill_addr + ADDR_W'(1);
        if (fill_addr == ADDR_W'(FILL_LAST)) begin
          state <= IDLE;
        end
      end
    end
  end

  // Read pipeline: regce at T+2, data presented and latched at T+3
  assign mem_regce = rd_two;
  assign rd_rdy    = rd_three;
  assign rd_live   = 8'({busy, opt[OPT_EN], mem_dout});

  // Hold the last read-back byte until the next read completes
  always_ff @(posedge clk) begin
    if (srst) begin
      rd_hold <= '0;
    end else if (rd_three) begin
      rd_hold <= rd_live;
    end
  end

  assign rd_data     = rd_three ? rd_live : rd_hold;
  assign le18_enable = opt[OPT_EN];

endmodule

// File: tb/tb_le18_port_ctrl.sv
// Scoreboard bench for le18_port_ctrl: stimulus pushes expected RAM writes
// and read-backs, a negedge monitor pops and compares them.
module tb_le18_port_ctrl;

  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        io_access = 1'b0;
  logic [7:0]  trs_a = 8'h00;
  logic [7:0]  trs_d = 8'h00;
  logic        trs_in_n = 1'b1;
  logic        trs_out_n = 1'b1;
  logic        mem_ce, mem_we, mem_regce;
  logic [13:0] mem_addr;
  logic [5:0]  mem_din;
  logic [5:0]  mem_dout;
  logic [7:0]  rd_data;
  logic        rd_rdy, le18_enable, busy;

  le18_port_ctrl dut (
    .clk         (clk),
    .srst        (srst),
    .io_access   (io_access),
    .trs_a       (trs_a),
    .trs_d       (trs_d),
    .trs_in_n    (trs_in_n),
    .trs_out_n   (trs_out_n),
    .mem_ce      (mem_ce),
    .mem_we      (mem_we),
    .mem_regce   (mem_regce),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .mem_dout    (mem_dout),
    .rd_data     (rd_data),
    .rd_rdy      (rd_rdy),
    .le18_enable (le18_enable),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM port A: read latch on ce, output register on regce
  logic [5:0] ram [0:16383];
  logic [5:0] lat;
  always @(posedge clk) begin
    if (mem_ce && mem_we) ram[mem_addr] <= mem_din;
    if (mem_ce && !mem_we) lat <= ram[mem_addr];
    if (mem_regce) mem_dout <= lat;
  end

  typedef struct {int cyc; logic [13:0] addr; logic [5:0] data;} wr_t;
  typedef struct {int cyc; logic [7:0] data;} rd_t;
  wr_t wq[$];
  rd_t rq[$];
  wr_t we_e;
  rd_t re_e;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [5:0] rx = 6'd0;
  logic [7:0] ry = 8'd0;
  logic [1:0] ropt = 2'd0;
  logic       exp_busy = 1'b0;
  logic [5:0] ref_mem [0:16383];
  bit         fill_mode = 1'b0;
  int         fill_next = 0;
  logic [5:0] fill_val_exp = 6'd0;
  int         busy_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name, input logic [63:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0h where no event was expected (cycle %0d)", name, act, cyc);
  endtask

  // Monitor: every DUT write / read-back is matched against the scoreboard
  always @(negedge clk) begin
    if (!srst) begin
      if (busy) busy_cnt++;
      if (mem_ce && mem_we) begin
        if (fill_mode && fill_next < 16384 && mem_din == fill_val_exp &&
            mem_addr == fill_next[13:0]) begin
          fill_next++;
        end else if (wq.size() > 0) begin
          we_e = wq.pop_front();
          check("wr_addr", mem_addr, we_e.addr);
          check("wr_data", mem_din, we_e.data);
          check("wr_cycle", cyc, we_e.cyc);
        end else begin
          flag("stray_write", {mem_addr, mem_din});
        end
      end
      if (rd_rdy) begin
        if (rq.size() > 0) begin
          re_e = rq.pop_front();
          check("rd_data", rd_data, re_e.data);
          check("rd_cycle", cyc, re_e.cyc);
        end else begin
          flag("stray_rd_rdy", rd_data);
        end
      end
    end
  end

  // One Z80 bus cycle; the model predicts its effects from the port rules
  task automatic z80(input bit is_out, input logic [7:0] a, input logic [7:0] d);
    logic [13:0] addr;
    @(posedge clk); #1;
    trs_a = a;
    trs_d = d;
    io_access = 1'b1;
    if (is_out) trs_out_n = 1'b0; else trs_in_n = 1'b0;
    addr = {ry, rx};
    if (is_out) begin
      case (a)
        8'hED: rx = d[5:0];
        8'hEE: ry = d;
        8'hEF: ropt = d[1:0];
        8'hEB: begin
          fill_mode = 1'b1;
          fill_next = 0;
          fill_val_exp = d[5:0];
          busy_cnt = 0;
        end
        8'hEC: begin
          wq.push_back('{cyc + 2, addr, d[5:0]});
          ref_mem[addr] = d[5:0];
        end
        default: ;
      endcase
    end else if (a == 8'hEC) begin
      rq.push_back('{cyc + 4, {exp_busy, ropt[0], ref_mem[addr]}});
    end
    if (a == 8'hEC && ropt[1]) begin
      if (rx == 6'd63) ry = ry + 8'd1;
      rx = rx + 6'd1;
    end
    repeat (3) @(posedge clk);
    #1;
    io_access = 1'b0;
    trs_out_n = 1'b1;
    trs_in_n = 1'b1;
    if (is_out && a == 8'hEF) check("le18_enable", le18_enable, ropt[0]);
    repeat (2) @(posedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_fill_done(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(posedge clk); #1;
      n++;
    end
    check("fill_terminates", busy, 1'b0);
    idle(3);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, {mem_ce, mem_we, mem_regce, rd_rdy, le18_enable, busy}, 0);
    check({name, "_data"}, {mem_addr, mem_din, rd_data}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 16384; i++) ref_mem[i] = 6'd0;

    // Reset state
    srst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    srst = 1'b0;
    idle(2);

    // Pointer write then data write at {3,5}
    z80(1, 8'hED, 8'd5);
    z80(1, 8'hEE, 8'd3);
    z80(1, 8'hEC, 8'h2A);

    // Auto-increment wrap of X and Y
    z80(1, 8'hEF, 8'h02);
    z80(1, 8'hED, 8'd63);
    z80(1, 8'hEE, 8'd255);
    z80(1, 8'hEC, 8'h11);
    z80(1, 8'hEC, 8'h22);
    z80(1, 8'hEC, 8'h33);

    // Read-back with overlay enable set
    z80(1, 8'hEF, 8'h01);
    z80(1, 8'hED, 8'd1);
    z80(1, 8'hEE, 8'd1);
    z80(1, 8'hEC, 8'h15);
    z80(0, 8'hEC, 8'h00);

    // Uncontended fill
    z80(1, 8'hEB, 8'h3F);
    wait_fill_done(20000);
    check("fill_writes", fill_next, 16384);
    check("fill_busy_cycles", busy_cnt, 16385);
    fill_mode = 1'b0;
    for (int i = 0; i < 16384; i++) ref_mem[i] = 6'h3F;

    // Randomised register / data traffic
    for (int k = 0; k < 80; k++) begin
      int op;
      logic [7:0] d;
      op = $urandom_range(0, 4);
      d = 8'($urandom);
      case (op)
        0: z80(1, 8'hED, d);
        1: z80(1, 8'hEE, d);
        2: z80(1, 8'hEF, d);
        3: z80(1, 8'hEC, d);
        default: z80(0, 8'hEC, d);
      endcase
    end
    idle(6);
    check("wq_drained", wq.size(), 0);
    check("rq_drained", rq.size(), 0);

    // Fill contended by one Z80 write and one Z80 read
    z80(1, 8'hEF, 8'h00);
    z80(1, 8'hED, 8'd63);
    z80(1, 8'hEE, 8'd255);
    z80(1, 8'hEB, 8'h15);
    exp_busy = 1'b1;
    z80(1, 8'hEC, 8'h2A);
    z80(0, 8'hEC, 8'h00);
    exp_busy = 1'b0;
    wait_fill_done(20000);
    check("cfill_writes", fill_next, 16384);
    check("cfill_busy_cycles", busy_cnt, 16387);
    fill_mode = 1'b0;
    for (int i = 0; i < 16384; i++) ref_mem[i] = 6'h15;
    z80(0, 8'hEC, 8'h00);

    // Reset in the middle of a fill
    z80(1, 8'hEF, 8'h03);
    z80(1, 8'hEB, 8'h0A);
    n = 0;
    while (!(mem_we && mem_addr == 14'd100) && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    check("fill_reached_100", mem_addr, 14'd100);
    srst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("srst_fill");
    srst = 1'b0;
    fill_mode = 1'b0;
    rx = 6'd0;
    ry = 8'd0;
    ropt = 2'd0;
    for (int i = 0; i <= 100; i++) ref_mem[i] = 6'h0A;
    idle(40);
    check("busy_after_srst", busy, 1'b0);
    z80(1, 8'hED, 8'd36);
    z80(1, 8'hEE, 8'd1);
    z80(0, 8'hEC, 8'h00);
    z80(1, 8'hED, 8'd37);
    z80(0, 8'hEC, 8'h00);
    idle(6);
    check("final_wq_drained", wq.size(), 0);
    check("final_rq_drained", rq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
